// File: rtl/axi_eth_tx_if.sv
// Byte-wide AXI-Stream link shared by the ARP/IPv4 payload sources and the MAC sink.
interface axi_eth_tx_if;
  logic [7:0] tdata;
  logic       tlast;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axi_eth_tx.sv
// Ethernet framer: arbitrates ARP and IPv4 payload streams round-robin, prepends the
// 14-byte MAC header and zero-pads short frames up to the 60-byte minimum.
module axi_eth_tx #(
  parameter int unsigned DEBUG   = 1,
  parameter logic [23:0] MAC_MSB = 24'h010203,
  parameter logic [23:0] MAC_LSB = 24'h040506
) (
  input  logic                clk,
  input  logic                aresetn,
  axi_eth_tx_if.slave         arp_axis,
  input  logic [47:0]         arp_tx_dst_mac,
  axi_eth_tx_if.slave         ip_axis,
  input  logic [47:0]         ip_tx_dst_mac,
  axi_eth_tx_if.master        mac_axis
);

  localparam logic [47:0] THIS_MAC = {MAC_MSB, MAC_LSB};
  localparam logic [15:0] ETH_ARP  = 16'h0806;
  localparam logic [15:0] ETH_IP   = 16'h0800;
  localparam logic [5:0]  LAST_MIN = 6'd59;
  localparam logic [5:0]  CNT_MAX  = 6'd63;
  localparam logic [5:0]  HDR_LAST = 6'd13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PAD
  } state_t;

  state_t      state_q, state_d;
  logic        srcIp_q, srcIp_d;
  logic        lastIp_q, lastIp_d;
  logic [47:0] dstMac_q, dstMac_d;
  logic [15:0] etherType_q, etherType_d;
  logic [5:0]  cnt_q, cnt_d;

  logic        srcValid, srcLast;
  logic [7:0]  srcData;
  logic [111:0] hdr, hdrShifted;
  logic [7:0]  macData;
  logic        macValid, macLast, arpReady, ipReady;
  logic        xfer, grantArp, grantIp;
  logic [5:0]  cntInc;

  assign srcValid   = srcIp_q ? ip_axis.tvalid : arp_axis.tvalid;
  assign srcLast    = srcIp_q ? ip_axis.tlast  : arp_axis.tlast;
  assign srcData    = srcIp_q ? ip_axis.tdata  : arp_axis.tdata;
  assign hdr        = {dstMac_q, THIS_MAC, etherType_q};
  assign hdrShifted = hdr << {cnt_q[3:0], 3'b000};
  assign cntInc     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 6'd1;

  // A tie goes to whichever source was not granted last.
  assign grantArp = arp_axis.tvalid && (!ip_axis.tvalid || lastIp_q);
  assign grantIp  = ip_axis.tvalid && !grantArp;

  always_comb begin
    macData  = 8'h00;
    macValid = 1'b0;
    macLast  = 1'b0;
    arpReady = 1'b0;
    ipReady  = 1'b0;
    case (state_q)
      S_HEADER: begin
        macValid = 1'b1;
        macData  = hdrShifted[111:104];
      end
      S_PAYLOAD: begin
        macValid = srcValid;
        macData  = srcData;
        macLast  = srcLast && (cnt_q >= LAST_MIN);
        if (srcIp_q) ipReady  = mac_axis.tready;
        else         arpReady = mac_axis.tready;
      end
      S_PAD: begin
        macValid = 1'b1;
        macLast  = (cnt_q == LAST_MIN);
      end
      default: ;
    endcase
  end

  assign xfer = macValid && mac_axis.tready;

  always_comb begin
    state_d     = state_q;
    srcIp_d     = srcIp_q;
    lastIp_d    = lastIp_q;
    dstMac_d    = dstMac_q;
    etherType_d = etherType_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grantArp || grantIp) begin
          srcIp_d     = grantIp;
          lastIp_d    = grantIp;
          dstMac_d    = grantIp ? ip_tx_dst_mac : arp_tx_dst_mac;
          etherType_d = grantIp ? ETH_IP : ETH_ARP;
          cnt_d       = 6'd0;
          state_d     = S_HEADER;
        end
      end
      S_HEADER: begin
        if (xfer) begin
          cnt_d = cntInc;
          if (cnt_q == HDR_LAST) state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          cnt_d = cntInc;
          if (srcLast) state_d = (cnt_q >= LAST_MIN) ? S_IDLE : S_PAD;
        end
      end
      S_PAD: begin
        if (xfer) begin
          cnt_d = cntInc;
          if (cnt_q == LAST_MIN) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset leaves lastIp set so that ARP wins the first tie.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      srcIp_q     <= 1'b0;
      lastIp_q    <= 1'b1;
      dstMac_q    <= 48'h0;
      etherType_q <= 16'h0;
      cnt_q       <= 6'd0;
    end else begin
      state_q     <= state_d;
      srcIp_q     <= srcIp_d;
      lastIp_q    <= lastIp_d;
      dstMac_q    <= dstMac_d;
      etherType_q <= etherType_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mac_axis.tdata  = macData;
  assign mac_axis.tvalid = macValid;
  assign mac_axis.tlast  = macLast;
  assign arp_axis.tready = arpReady;
  assign ip_axis.tready  = ipReady;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (DEBUG != 0 && aresetn && state_q == S_IDLE && (grantArp || grantIp))
      $display("%0t axi_eth_tx frame start: DST %012h SRC %012h TYPE %04h",
               $time, dstMac_d, THIS_MAC, etherType_d);
  end
`endif

endmodule

// File: tb/tb_axi_eth_tx.sv
// Directed-random bench for axi_eth_tx: frames are predicted from header/pad rules and
// compared byte by byte (data and tlast) against what the MAC side accepts.
module tb_axi_eth_tx;

  typedef logic [7:0] bytes_t[$];
  typedef logic [8:0] frame_t[$];

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [47:0] arpDst, ipDst;
  bit          macStall = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          cycleCount = 0;

  logic [7:0]  capData[$];
  logic        capLast[$];
  int          capCyc[$];
  logic        prevHold = 1'b0;
  logic [8:0]  prevByte = 9'h0;

  axi_eth_tx_if arpIf ();
  axi_eth_tx_if ipIf ();
  axi_eth_tx_if macIf ();

  axi_eth_tx #(.DEBUG(1)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .arp_axis      (arpIf),
    .arp_tx_dst_mac(arpDst),
    .ip_axis       (ipIf),
    .ip_tx_dst_mac (ipDst),
    .mac_axis      (macIf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  always begin
    macIf.tready = macStall ? ($urandom_range(1) == 1) : 1'b1;
    @(posedge clk);
    #1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Records every accepted MAC byte; a stalled byte must still be on the bus next cycle.
  always @(negedge clk) begin
    if (!aresetn) begin
      capData.delete();
      capLast.delete();
      capCyc.delete();
      prevHold = 1'b0;
    end else begin
      if (prevHold)
        checkOutput("stall_hold", {22'd0, macIf.tvalid, macIf.tlast, macIf.tdata}, {22'd0, 1'b1, prevByte});
      if (macIf.tvalid && macIf.tready) begin
        capData.push_back(macIf.tdata);
        capLast.push_back(macIf.tlast);
        capCyc.push_back(cycleCount);
      end
      prevHold = macIf.tvalid && !macIf.tready;
      prevByte = {macIf.tlast, macIf.tdata};
    end
  end

  function automatic bytes_t seqBytes(input int n, input int first);
    bytes_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(first + i));
    return q;
  endfunction

  function automatic bytes_t randBytes(input int n);
    bytes_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    return q;
  endfunction

  function automatic frame_t buildFrame(input logic [47:0] dst, input bit isIp, input bytes_t pl);
    frame_t f;
    logic [47:0] src = 48'h010203040506;
    logic [15:0] et = isIp ? 16'h0800 : 16'h0806;
    for (int i = 0; i < 6; i++) f.push_back({1'b0, 8'(dst >> (40 - 8 * i))});
    for (int i = 0; i < 6; i++) f.push_back({1'b0, 8'(src >> (40 - 8 * i))});
    f.push_back({1'b0, et[15:8]});
    f.push_back({1'b0, et[7:0]});
    foreach (pl[i]) f.push_back({1'b0, pl[i]});
    while (f.size() < 60) f.push_back(9'h000);
    f[f.size() - 1][8] = 1'b1;
    return f;
  endfunction

  task automatic setSrc(input bit isIp, input bit v, input logic [7:0] d, input bit l);
    if (isIp) begin
      ipIf.tvalid = v; ipIf.tdata = d; ipIf.tlast = l;
    end else begin
      arpIf.tvalid = v; arpIf.tdata = d; arpIf.tlast = l;
    end
  endtask

  task automatic applyStimulus(input bit isIp, input bytes_t pl, input int gapPct, output int startCyc);
    bit r;
    int budget;
    startCyc = 0;
    for (int i = 0; i < pl.size(); i++) begin
      if (gapPct > 0 && $urandom_range(99) < gapPct) begin
        setSrc(isIp, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
      end
      setSrc(isIp, 1'b1, pl[i], i == pl.size() - 1);
      if (i == 0) startCyc = cycleCount;
      r = 1'b0;
      budget = 0;
      while (!r && budget < 3000) begin
        @(negedge clk);
        r = isIp ? ipIf.tready : arpIf.tready;
        @(posedge clk);
        #1;
        budget++;
      end
      if (!r) begin
        checkOutput("src_handshake", {31'd0, r}, 32'd1);
        break;
      end
    end
    setSrc(isIp, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic checkFrame(input string tag, input frame_t exp, output int firstCyc, output int lastCyc);
    int budget = 0;
    logic avail;
    firstCyc = 0;
    lastCyc = 0;
    while (capData.size() < exp.size() && budget < 5000) begin
      @(negedge clk);
      #2;
      budget++;
    end
    avail = capData.size() >= exp.size();
    checkOutput({tag, "_complete"}, {31'd0, avail}, 32'd1);
    if (avail) begin
      firstCyc = capCyc[0];
      for (int i = 0; i < exp.size(); i++) begin
        lastCyc = capCyc[0];
        checkOutput($sformatf("%s_byte%0d", tag, i), {23'd0, capLast[0], capData[0]}, {23'd0, exp[i]});
        void'(capData.pop_front());
        void'(capLast.pop_front());
        void'(capCyc.pop_front());
      end
    end
  endtask

  task automatic checkQuiet(input string tag);
    repeat (4) @(posedge clk);
    #1;
    checkOutput({tag, "_extra"}, capData.size(), 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, macIf.tvalid}, 32'd0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    int sA, sB, f0, l0, f1, l1, f2, l2, f3, l3, budget;
    bytes_t pA1, pA2, pI1, pI2, pl;
    frame_t fr;

    setSrc(1'b0, 1'b0, 8'h00, 1'b0);
    setSrc(1'b1, 1'b0, 8'h00, 1'b0);
    arpDst = 48'h0;
    ipDst  = 48'h0;
    #2;
    checkOutput("rst_tvalid", {31'd0, macIf.tvalid}, 32'd0);
    checkOutput("rst_tlast", {31'd0, macIf.tlast}, 32'd0);
    checkOutput("rst_tdata", {24'd0, macIf.tdata}, 32'd0);
    checkOutput("rst_arp_tready", {31'd0, arpIf.tready}, 32'd0);
    checkOutput("rst_ip_tready", {31'd0, ipIf.tready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    checkQuiet("post_reset");

    $display("[TB] ARP broadcast, 28-byte payload");
    arpDst = 48'hFFFFFFFFFFFF;
    pl = seqBytes(28, 1);
    fr = buildFrame(arpDst, 1'b0, pl);
    fork
      applyStimulus(1'b0, pl, 0, sA);
      checkFrame("arp28", fr, f0, l0);
    join
    checkOutput("arp28_latency", f0 - sA, 32'd1);
    checkQuiet("arp28");

    $display("[TB] IPv4, 100-byte payload");
    @(posedge clk);
    #1;
    ipDst = 48'h0A0B0C0D0E0F;
    pl = randBytes(100);
    fr = buildFrame(ipDst, 1'b1, pl);
    checkOutput("ip100_len", fr.size(), 32'd114);
    fork
      applyStimulus(1'b1, pl, 0, sB);
      checkFrame("ip100", fr, f0, l0);
    join
    checkQuiet("ip100");

    $display("[TB] ARP, 45-byte payload");
    @(posedge clk);
    #1;
    arpDst = 48'h112233445566;
    pl = randBytes(45);
    fr = buildFrame(arpDst, 1'b0, pl);
    fork
      applyStimulus(1'b0, pl, 0, sA);
      checkFrame("arp45", fr, f0, l0);
    join
    checkQuiet("arp45");

    $display("[TB] simultaneous ARP and IPv4 requests after reset");
    pulseReset();
    @(posedge clk);
    #1;
    arpDst = 48'hA1A2A3A4A5A6;
    ipDst  = 48'hB1B2B3B4B5B6;
    pA1 = randBytes(28);
    pI1 = randBytes(50);
    pA2 = randBytes(10);
    pI2 = randBytes(70);
    fork
      begin
        applyStimulus(1'b0, pA1, 0, sA);
        applyStimulus(1'b0, pA2, 0, sA);
      end
      begin
        applyStimulus(1'b1, pI1, 0, sB);
        applyStimulus(1'b1, pI2, 0, sB);
      end
      begin
        checkFrame("rr_arp1", buildFrame(arpDst, 1'b0, pA1), f0, l0);
        checkFrame("rr_ip1", buildFrame(ipDst, 1'b1, pI1), f1, l1);
        checkFrame("rr_arp2", buildFrame(arpDst, 1'b0, pA2), f2, l2);
        checkFrame("rr_ip2", buildFrame(ipDst, 1'b1, pI2), f3, l3);
      end
    join
    checkOutput("rr_gap1", f1 - l0, 32'd2);
    checkOutput("rr_gap2", f2 - l1, 32'd2);
    checkOutput("rr_gap3", f3 - l2, 32'd2);
    checkQuiet("rr");

    $display("[TB] IPv4 46-byte payload with MAC stalls and source gaps");
    @(posedge clk);
    #1;
    ipDst = 48'h0C0D0E0F1011;
    pl = randBytes(46);
    fr = buildFrame(ipDst, 1'b1, pl);
    macStall = 1'b1;
    fork
      applyStimulus(1'b1, pl, 40, sB);
      checkFrame("stall46", fr, f0, l0);
    join
    macStall = 1'b0;
    checkQuiet("stall46");

    $display("[TB] IPv4, 1-byte payload");
    @(posedge clk);
    #1;
    pl = seqBytes(1, 8'h5A);
    fr = buildFrame(ipDst, 1'b1, pl);
    fork
      applyStimulus(1'b1, pl, 0, sB);
      checkFrame("ip1", fr, f0, l0);
    join
    checkQuiet("ip1");

    $display("[TB] reset during header byte 8");
    @(posedge clk);
    #1;
    arpDst = 48'hDEADBEEF0042;
    pl = randBytes(20);
    fr = buildFrame(arpDst, 1'b0, pl);
    fork
      applyStimulus(1'b0, pl, 0, sA);
      begin
        budget = 0;
        while (capData.size() < 9 && budget < 500) begin
          @(negedge clk);
          #1;
          budget++;
        end
        checkOutput("hdr8_reached", capData.size(), 32'd9);
        if (capData.size() >= 9) checkOutput("hdr8_byte", {24'd0, capData[8]}, 32'h03);
        aresetn = 1'b0;
        #1;
        checkOutput("hdr8_rst_tvalid", {31'd0, macIf.tvalid}, 32'd0);
        checkOutput("hdr8_rst_tdata", {24'd0, macIf.tdata}, 32'd0);
        checkOutput("hdr8_rst_tlast", {31'd0, macIf.tlast}, 32'd0);
        checkOutput("hdr8_rst_arp_tready", {31'd0, arpIf.tready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        checkFrame("hdr8_restart", fr, f0, l0);
      end
    join
    checkQuiet("hdr8");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_eth_tx.md
AXI_ETH_TX -- requirements
Module: axi_eth_tx

Interface
REQ-001 Parameter DEBUG, default 1: nonzero enables a $display of dst MAC, src MAC and ethertype at each frame start.
REQ-002 Parameter MAC_MSB, default 24'h010203: upper 24 bits of the source MAC.
REQ-003 Parameter MAC_LSB, default 24'h040506: lower 24 bits of the source MAC; THIS_MAC = {MAC_MSB, MAC_LSB}.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-006 arp_axis_tdata/tlast/tvalid  input  8/1/1  ARP payload stream.
REQ-007 arp_axis_tready  output  1  ARP payload accept.
REQ-008 arp_tx_dst_mac  input  48  ARP frame destination MAC; stable while arp_axis_tvalid before first byte accepted.
REQ-009 ip_axis_tdata/tlast/tvalid  input  8/1/1  IPv4 payload stream.
REQ-010 ip_axis_tready  output  1  IPv4 payload accept.
REQ-011 ip_tx_dst_mac  input  48  IPv4 frame destination MAC; same stability rule as REQ-008.
REQ-012 mac_axis_tdata/tlast/tvalid  output  8/1/1  Ethernet frame stream toward MAC (no preamble, no FCS).
REQ-013 mac_axis_tready  input  1  MAC accept.

Function
REQ-014 States S_IDLE, S_HEADER, S_PAYLOAD, S_PAD; a byte transfers only when tvalid and tready are both high.
REQ-015 S_IDLE: mac_axis_tvalid=0, both source treadys=0; a pending source (tvalid=1) is granted on that edge.
REQ-016 Arbitration round-robin: both pending -> source not granted last wins; after reset ARP wins the first tie.
REQ-017 On grant: latch source id, dst MAC from that source's *_tx_dst_mac, ethertype 16'h0806 (ARP) or 16'h0800 (IPv4); byte counter=0; go S_HEADER.
REQ-018 S_HEADER: mac_axis_tvalid=1, tlast=0, both source treadys=0; bytes 0-5 dst MAC MSB first, 6-11 THIS_MAC MSB first, 12-13 ethertype MSB first.
REQ-019 Header byte index advances only on mac transfer; after byte 13 transfers go S_PAYLOAD.
REQ-020 S_PAYLOAD: combinational passthrough of granted source: mac tdata=src tdata, mac tvalid=src tvalid, src tready=mac_axis_tready; other source tready=0.
REQ-021 Byte counter counts every transferred frame byte (header included), 6 bits, saturating at 63.
REQ-022 Payload byte with src tlast and counter>=59: mac tlast=1; after transfer go S_IDLE.
REQ-023 Payload byte with src tlast and counter<59: mac tlast=0; after transfer go S_PAD.
REQ-024 S_PAD: mac tvalid=1, tdata=8'h00, source treadys=0, tlast=1 iff counter==59; after tlast transfer go S_IDLE.
REQ-025 Minimum emitted frame therefore 60 bytes; frames >=60 bytes emitted unpadded, no upper length limit.
REQ-026 mac_axis_tready low holds all outputs and state stable (header and pad bytes do not change while stalled).
REQ-027 Source tvalid deassertion mid-payload: mac tvalid follows it low; state retained, no byte inserted.
REQ-028 Source assertions arriving during an active frame wait; grant evaluated only in S_IDLE, earliest the cycle after the closing tlast transfer.
REQ-029 Latency: grant edge to first header byte valid = 1 cycle; back-to-back frames separated by exactly one idle cycle.
REQ-030 If DEBUG, one $display per frame on the grant edge, format: time, tag, DST %012h, SRC %012h, TYPE %04h.

Reset
REQ-031 aresetn low asynchronously forces S_IDLE, counter=0, latched MAC/ethertype=0, last-grant=IPv4 (so ARP wins first tie).
REQ-032 During reset: mac_axis_tvalid=0, tlast=0, tdata=0, arp_axis_tready=0, ip_axis_tready=0.
REQ-033 Reset mid-frame truncates the frame without tlast; after release the next frame starts with a full header.

Verification
REQ-034 ARP, dst FFFFFFFFFFFF, 28-byte payload 01..1C, mac_axis_tready=1 -> FF x6, 01 02 03 04 05 06, 08 06, 01..1C, 18 bytes 00, tlast on byte 59, 60 bytes total.
REQ-035 IPv4, dst 0A0B0C0D0E0F, 100-byte payload -> 114 bytes, ethertype 08 00, tlast on byte 113 only, no padding.
REQ-036 ARP and IPv4 tvalid asserted same cycle after reset, two frames each -> order ARP, IP, ARP, IP; one idle cycle between frames.
REQ-037 Random mac_axis_tready (50%) and source tvalid gaps on 46-byte IPv4 payload -> byte stream identical to no-stall run (60 bytes, no pad); no byte lost or duplicated.
REQ-038 Payload of exactly 45 bytes -> one pad byte 00 with tlast, 60 bytes total; payload of 1 byte -> 45 pad bytes.
REQ-039 aresetn low during header byte 8 -> outputs zero that cycle; after release pending frame restarts at dst MAC byte 0.
